instr_fetch: RTL and testbench

Instruction fetch stage: owns the program counter, issues word reads to instruction memory, and presents each fetched instruction with its PC to the decode stage over a valid/ready interface. It sits at the producer end of the if/id interface the decoder consumes. It accepts PC redirects from the branch/jump resolution path (decode's `pc_branch` when `is_jump_instr` resolves taken) and from trap logic. Stale in-flight responses are discarded on redirect.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage - owns the PC, reads instruction memory one word at a
//            time and hands (pc, instruction, fault) to decode via valid/ready.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        out_fetch_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam logic [1:0] c_REQ   = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_DROP  = 2'd2;
    localparam logic [1:0] c_FAULT = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_out_valid;
    logic [31:0] r_out_instruction;
    logic [31:0] r_out_pc;
    logic        r_out_fetch_fault;

    logic w_buf_free;
    logic w_aligned;
    logic w_req_valid;
    logic w_req_fire;

    assign w_buf_free  = !r_out_valid || out_ready;
    assign w_aligned   = (r_pc[1:0] == 2'b00);
    assign w_req_valid = (r_state == c_REQ) && w_aligned && w_buf_free;
    assign w_req_fire  = w_req_valid && imem_req_ready;

    assign imem_req_valid  = w_req_valid;
    assign imem_req_addr   = r_pc;
    assign out_valid       = r_out_valid;
    assign out_instruction = r_out_instruction;
    assign out_pc          = r_out_pc;
    assign out_fetch_fault = r_out_fetch_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= c_REQ;
            r_pc              <= RESET_PC;
            r_out_valid       <= 1'b0;
            r_out_instruction <= 32'd0;
            r_out_pc          <= 32'd0;
            r_out_fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect wins over everything; any response still owed by
            // memory for the old PC must be swallowed in DROP.
            r_pc        <= redirect_pc;
            r_out_valid <= 1'b0;
            case (r_state)
                c_REQ:   r_state <= w_req_fire ? c_DROP : c_REQ;
                c_WAIT:  r_state <= imem_resp_valid ? c_REQ : c_DROP;
                // A stale response landing now is the one DROP was waiting for.
                c_DROP:  r_state <= imem_resp_valid ? c_REQ : c_DROP;
                default: r_state <= c_REQ;
            endcase
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                c_REQ: begin
                    if (w_buf_free && !w_aligned) begin
                        r_out_valid       <= 1'b1;
                        r_out_pc          <= r_pc;
                        r_out_instruction <= 32'd0;
                        r_out_fetch_fault <= 1'b1;
                        r_state           <= c_FAULT;
                    end else if (w_req_fire) begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // Buffer is free here: a request only issues when it is.
                    if (imem_resp_valid) begin
                        r_out_valid       <= 1'b1;
                        r_out_pc          <= r_pc;
                        r_out_instruction <= imem_resp_error ? 32'd0 : imem_resp_data;
                        r_out_fetch_fault <= imem_resp_error;
                        if (imem_resp_error) begin
                            r_state <= c_FAULT;
                        end else begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= c_REQ;
                        end
                    end
                end
                c_DROP: begin
                    if (imem_resp_valid) begin
                        r_state <= c_REQ;
                    end
                end
                default: r_state <= c_FAULT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Scoreboard bench for instr_fetch with a latency-programmable memory.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic        out_fetch_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch #(.RESET_PC(c_RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_error (imem_resp_error),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .out_fetch_fault (out_fetch_fault),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    exp_t        exp_out[$];
    logic [31:0] exp_req[$];
    int          checks   = 0;
    int          failures = 0;
    int          n_fire   = 0;
    int          lat      = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_out(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        exp_t e;
        e.pc = pc; e.instr = instr; e.fault = fault;
        exp_out.push_back(e);
    endtask

    // Memory model: one outstanding request, response `lat` cycles after acceptance.
    initial begin
        int          cnt;
        logic        pend;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; paddr = 32'd0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        imem_resp_error = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && imem_req_valid && imem_req_ready) begin
                pend  = 1'b1;
                paddr = imem_req_addr;
                cnt   = lat;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_word(paddr);
                    imem_resp_error = (paddr == err_addr);
                    pend            = 1'b0;
                end
            end
        end
    end

    // Monitor: request addresses and consumed entries against the scoreboard.
    initial begin
        logic prev_ov;
        logic prev_resp;
        exp_t e;
        prev_ov = 1'b0; prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_req_valid && imem_req_ready) begin
                    n_fire++;
                    if (exp_req.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_req: got addr %h expected no request", imem_req_addr);
                    end else begin
                        chk("req_addr", imem_req_addr, exp_req.pop_front());
                    end
                end
                if (out_valid && !prev_ov && !out_fetch_fault)
                    chk("resp_to_out_latency", {31'd0, prev_resp}, 32'd1);
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_out: got pc %h expected no entry", out_pc);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out_pc", out_pc, e.pc);
                        chk("out_instruction", out_instruction, e.instr);
                        chk("out_fetch_fault", {31'd0, out_fetch_fault}, {31'd0, e.fault});
                    end
                end
                prev_ov   = out_valid;
                prev_resp = imem_resp_valid;
            end else begin
                prev_ov   = 1'b0;
                prev_resp = 1'b0;
            end
        end
    end

    // Open memory until n more requests are accepted, then close it again.
    task automatic fetch_n(input int n);
        int target;
        bit done;
        target = n_fire + n;
        done   = 1'b0;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            if (n_fire >= target) done = 1'b1;
        end
        #1;
        imem_req_ready = 1'b0;
        chk("fetch_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_req.size() == 0 && exp_out.size() == 0) done = 1'b1;
        end
        chk("drain_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instruction", out_instruction, 32'd0);
        chk("rst_out_fault", {31'd0, out_fetch_fault}, 32'd0);
        chk("rst_req_addr", imem_req_addr, c_RESET_PC);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-wait streaming from RESET_PC.
        chk("first_cycle_req_valid", {31'd0, imem_req_valid}, 32'd1);
        exp_req.push_back(32'h100); exp_req.push_back(32'h104); exp_req.push_back(32'h108);
        push_out(32'h100, mem_word(32'h100), 1'b0);
        push_out(32'h104, mem_word(32'h104), 1'b0);
        push_out(32'h108, mem_word(32'h108), 1'b0);
        fetch_n(3);
        drain();

        // Backpressure: entry at 0x10C held for 5 cycles.
        out_ready = 1'b0;
        exp_req.push_back(32'h10C); exp_req.push_back(32'h110);
        push_out(32'h10C, mem_word(32'h10C), 1'b0);
        push_out(32'h110, mem_word(32'h110), 1'b0);
        fetch_n(1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, 32'h10C);
            chk("hold_instruction", out_instruction, mem_word(32'h10C));
            chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("release_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("release_req_addr", imem_req_addr, 32'h110);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        drain();

        // Redirect while waiting; stale response arrives two cycles later.
        lat = 3;
        exp_req.push_back(32'h114);
        fetch_n(1);
        exp_req.push_back(32'h200);
        push_out(32'h200, mem_word(32'h200), 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop_no_out", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
        end
        lat = 1;
        fetch_n(1);
        drain();

        // Redirect coincident with the response.
        exp_req.push_back(32'h204);
        fetch_n(1);
        exp_req.push_back(32'h280);
        push_out(32'h280, mem_word(32'h280), 1'b0);
        redirect_to(32'h280);
        fetch_n(1);
        drain();

        // Redirect coincident with the request handshake.
        exp_req.push_back(32'h284); exp_req.push_back(32'h2C0);
        push_out(32'h2C0, mem_word(32'h2C0), 1'b0);
        imem_req_ready = 1'b1;
        redirect_to(32'h2C0);
        imem_req_ready = 1'b0;
        fetch_n(1);
        drain();

        // Misaligned redirect, then recovery.
        push_out(32'h302, 32'd0, 1'b1);
        redirect_to(32'h302);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("misaligned_no_req", {31'd0, imem_req_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        exp_req.push_back(32'h400);
        push_out(32'h400, mem_word(32'h400), 1'b0);
        redirect_to(32'h400);
        fetch_n(1);
        drain();

        // Access fault at 0x108, held in the buffer, then reset mid-FAULT.
        out_ready = 1'b0;
        err_addr  = 32'h108;
        redirect_to(32'h108);
        exp_req.push_back(32'h108);
        fetch_n(1);
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_valid", {31'd0, out_valid}, 32'd1);
            chk("err_pc", out_pc, 32'h108);
            chk("err_instruction", out_instruction, 32'd0);
            chk("err_fault", {31'd0, out_fetch_fault}, 32'd1);
            chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_pc", out_pc, 32'd0);
        chk("arst_out_instruction", out_instruction, 32'd0);
        chk("arst_out_fault", {31'd0, out_fetch_fault}, 32'd0);
        chk("arst_req_addr", imem_req_addr, c_RESET_PC);
        chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b0;
        err_addr       = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        exp_req.push_back(32'h100);
        push_out(32'h100, mem_word(32'h100), 1'b0);
        fetch_n(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
